// File: rtl/radix2_bf_pipe.sv
// radix2_bf_pipe: three-register pipelined radix-2 FFT butterfly.
//
// A sample presented in cycle c (in_valid=1, ce=1) is captured at the end of
// that cycle. It is visible on the outputs from cycle c+3 when ce stays high.
// Every ce=0 cycle adds one cycle of latency.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   ce                  pipeline advance; 0 freezes every register except ovf_clr handling
//   in_valid            input sample valid (only meaningful while ce=1)
//   dif_mode            1 = DIF (twiddle after subtract), 0 = DIT (twiddle first)
//   scale               1 = halve both outputs with rounding
//   cos_data, sin_data  twiddle W = cos + j*sin, Q2.(bit_width_tw_factor-2)
//   Re_i1/Im_i1         input a
//   Re_i2/Im_i2         input b
//   out_valid           output sample valid
//   Re_o1/Im_o1         output 1 (a+b for DIF, a+b*W for DIT)
//   Re_o2/Im_o2         output 2 ((a-b)*W for DIF, a-b*W for DIT)
//   ovf, ovf_clr        sticky overflow flag and its synchronous clear
//
// Handshake: a sample is transferred on a rising edge where ce=1 and
// in_valid=1; there is no ready, the only flow control is ce, and the
// producer must hold in_valid low while ce=0. A result is presented on the
// edge where ce=1 leaves out_valid=1; out_valid and the data then hold until
// the next enabled edge.
module radix2_bf_pipe #(
    parameter int bit_width           = 16,
    parameter int bit_width_tw_factor = 16,
    parameter int SATURATE            = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  logic                           in_valid,
    input  logic                           dif_mode,
    input  logic                           scale,
    input  logic [bit_width_tw_factor-1:0] cos_data,
    input  logic [bit_width_tw_factor-1:0] sin_data,
    input  logic [bit_width-1:0]           Re_i1,
    input  logic [bit_width-1:0]           Im_i1,
    input  logic [bit_width-1:0]           Re_i2,
    input  logic [bit_width-1:0]           Im_i2,
    output logic                           out_valid,
    output logic [bit_width-1:0]           Re_o1,
    output logic [bit_width-1:0]           Im_o1,
    output logic [bit_width-1:0]           Re_o2,
    output logic [bit_width-1:0]           Im_o2,
    output logic                           ovf,
    input  logic                           ovf_clr
);

    localparam int BW = bit_width;
    localparam int TW = bit_width_tw_factor;
    // Wide enough for a full complex product sum of a (BW+1)-bit value with
    // a TW-bit twiddle plus the rounding constant.
    localparam int PW = BW + TW + 2;

    localparam logic signed [PW-1:0] ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic signed [PW-1:0] RND  = ONE <<< (TW-3);
    localparam logic signed [PW-1:0] MAXV = {{(PW-BW+1){1'b0}}, {(BW-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(PW-BW+1){1'b1}}, {(BW-1){1'b0}}};
    localparam logic [BW-1:0]        MAX_O = {1'b0, {(BW-1){1'b1}}};
    localparam logic [BW-1:0]        MIN_O = {1'b1, {(BW-1){1'b0}}};

    function automatic logic signed [PW-1:0] ext_in(input logic [BW-1:0] x);
        return {{(PW-BW){x[BW-1]}}, x};
    endfunction

    function automatic logic signed [PW-1:0] ext_s(input logic [BW:0] x);
        return {{(PW-BW-1){x[BW]}}, x};
    endfunction

    function automatic logic signed [PW-1:0] ext_tw(input logic [TW-1:0] x);
        return {{(PW-TW){x[TW-1]}}, x};
    endfunction

    // Round half up, then drop the Q2 fraction bits.
    function automatic logic signed [PW-1:0] rnd(input logic signed [PW-1:0] p);
        return (p + RND) >>> (TW-2);
    endfunction

    function automatic logic fit_ovf(input logic signed [PW-1:0] y);
        return (y > MAXV) || (y < MINV);
    endfunction

    function automatic logic [BW-1:0] fit(input logic signed [PW-1:0] y);
        if (SATURATE != 0) begin
            if (y > MAXV) return MAX_O;
            if (y < MINV) return MIN_O;
        end
        return y[BW-1:0];
    endfunction

    // Valid / tag pipeline
    logic v1_q, v2_q, v3_q;
    logic dif1_q, scl1_q, dif2_q, scl2_q;

    // Stage 1: s1_a holds a+b (DIF) or a (DIT); s1_d holds a-b (DIF only);
    // s1_p holds the four partial products of b with W (DIT only).
    logic [BW:0]          s1_a_re_d, s1_a_im_d, s1_d_re_d, s1_d_im_d;
    logic [BW:0]          s1_a_re_q, s1_a_im_q, s1_d_re_q, s1_d_im_q;
    logic [TW-1:0]        s1_cos_q, s1_sin_q;
    logic signed [PW-1:0] s1_p_d [4];
    logic signed [PW-1:0] s1_p_q [4];
    logic signed [PW-1:0] b_re_w, b_im_w, c1_w, sn1_w;

    // Stage 2: s2_p holds the four partial products of d with W (DIF) or the
    // rounded t = b*W in slots 0/1 (DIT).
    logic [BW:0]          s2_a_re_q, s2_a_im_q;
    logic signed [PW-1:0] s2_p_d [4];
    logic signed [PW-1:0] s2_p_q [4];
    logic signed [PW-1:0] d_re_w, d_im_w, c2_w, sn2_w;

    // Stage 3: full-precision results, then scale and fit
    logic signed [PW-1:0] a_re3_w, a_im3_w;
    logic signed [PW-1:0] y [4];
    logic [3:0]           y_ovf;
    logic [BW-1:0]        o_d [4];
    logic [BW-1:0]        o_q [4];
    logic                 ovf_d, ovf_q;

    always_comb begin
        b_re_w    = ext_in(Re_i2);
        b_im_w    = ext_in(Im_i2);
        c1_w      = ext_tw(cos_data);
        sn1_w     = ext_tw(sin_data);
        s1_d_re_d = {Re_i1[BW-1], Re_i1} - {Re_i2[BW-1], Re_i2};
        s1_d_im_d = {Im_i1[BW-1], Im_i1} - {Im_i2[BW-1], Im_i2};
        s1_a_re_d = dif_mode ? ({Re_i1[BW-1], Re_i1} + {Re_i2[BW-1], Re_i2})
                             : {Re_i1[BW-1], Re_i1};
        s1_a_im_d = dif_mode ? ({Im_i1[BW-1], Im_i1} + {Im_i2[BW-1], Im_i2})
                             : {Im_i1[BW-1], Im_i1};
        s1_p_d[0] = b_re_w * c1_w;
        s1_p_d[1] = b_im_w * sn1_w;
        s1_p_d[2] = b_im_w * c1_w;
        s1_p_d[3] = b_re_w * sn1_w;
    end

    always_comb begin
        d_re_w = ext_s(s1_d_re_q);
        d_im_w = ext_s(s1_d_im_q);
        c2_w   = ext_tw(s1_cos_q);
        sn2_w  = ext_tw(s1_sin_q);
        for (int k = 0; k < 4; k++) s2_p_d[k] = '0;
        if (dif1_q) begin
            s2_p_d[0] = d_re_w * c2_w;
            s2_p_d[1] = d_im_w * sn2_w;
            s2_p_d[2] = d_im_w * c2_w;
            s2_p_d[3] = d_re_w * sn2_w;
        end else begin
            s2_p_d[0] = rnd(s1_p_q[0] - s1_p_q[1]);
            s2_p_d[1] = rnd(s1_p_q[2] + s1_p_q[3]);
        end
    end

    always_comb begin
        a_re3_w = ext_s(s2_a_re_q);
        a_im3_w = ext_s(s2_a_im_q);
        if (dif2_q) begin
            y[0] = a_re3_w;
            y[1] = a_im3_w;
            y[2] = rnd(s2_p_q[0] - s2_p_q[1]);
            y[3] = rnd(s2_p_q[2] + s2_p_q[3]);
        end else begin
            y[0] = a_re3_w + s2_p_q[0];
            y[1] = a_im3_w + s2_p_q[1];
            y[2] = a_re3_w - s2_p_q[0];
            y[3] = a_im3_w - s2_p_q[1];
        end
        for (int k = 0; k < 4; k++) begin
            if (scl2_q) y[k] = (y[k] + ONE) >>> 1;
            y_ovf[k] = fit_ovf(y[k]);
            o_d[k]   = fit(y[k]);
        end
        // Set dominates clear when both happen on the same edge.
        ovf_d = (ovf_q & ~ovf_clr) | (ce & v2_q & (|y_ovf));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            dif1_q    <= 1'b0;
            scl1_q    <= 1'b0;
            dif2_q    <= 1'b0;
            scl2_q    <= 1'b0;
            s1_a_re_q <= '0;
            s1_a_im_q <= '0;
            s1_d_re_q <= '0;
            s1_d_im_q <= '0;
            s1_cos_q  <= '0;
            s1_sin_q  <= '0;
            s2_a_re_q <= '0;
            s2_a_im_q <= '0;
            for (int k = 0; k < 4; k++) begin
                s1_p_q[k] <= '0;
                s2_p_q[k] <= '0;
                o_q[k]    <= '0;
            end
            ovf_q     <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (ce) begin
                v1_q <= in_valid;
                v2_q <= v1_q;
                v3_q <= v2_q;
                if (in_valid) begin
                    dif1_q    <= dif_mode;
                    scl1_q    <= scale;
                    s1_a_re_q <= s1_a_re_d;
                    s1_a_im_q <= s1_a_im_d;
                    s1_d_re_q <= s1_d_re_d;
                    s1_d_im_q <= s1_d_im_d;
                    s1_cos_q  <= cos_data;
                    s1_sin_q  <= sin_data;
                    for (int k = 0; k < 4; k++) s1_p_q[k] <= s1_p_d[k];
                end
                if (v1_q) begin
                    dif2_q    <= dif1_q;
                    scl2_q    <= scl1_q;
                    s2_a_re_q <= s1_a_re_q;
                    s2_a_im_q <= s1_a_im_q;
                    for (int k = 0; k < 4; k++) s2_p_q[k] <= s2_p_d[k];
                end
                if (v2_q) begin
                    for (int k = 0; k < 4; k++) o_q[k] <= o_d[k];
                end
            end
        end
    end

    assign out_valid = v3_q;
    assign Re_o1     = o_q[0];
    assign Im_o1     = o_q[1];
    assign Re_o2     = o_q[2];
    assign Im_o2     = o_q[3];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_radix2_bf_pipe.sv
// Bench for radix2_bf_pipe: directed test-plan cases plus a randomized stream
// with ce stalls and ovf_clr pulses, checked by a queue-based scoreboard.
module tb_radix2_bf_pipe;

    localparam int BW = 16;
    localparam int TW = 16;
    localparam int W  = 4 * BW + 1;   // {ovf_of_sample, o1_re, o1_im, o2_re, o2_im}
    localparam longint MAXL = (longint'(1) << (BW - 1)) - 1;
    localparam longint MINL = -(longint'(1) << (BW - 1));
    localparam longint HALF = longint'(1) << (TW - 3);

    logic          clk = 1'b0;
    logic          rst, ce, in_valid, dif_mode, scale, ovf_clr;
    logic [TW-1:0] cos_data, sin_data;
    logic [BW-1:0] Re_i1, Im_i1, Re_i2, Im_i2;
    logic          out_valid, ovf;
    logic [BW-1:0] Re_o1, Im_o1, Re_o2, Im_o2;

    radix2_bf_pipe #(.bit_width(BW), .bit_width_tw_factor(TW), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .dif_mode(dif_mode),
        .scale(scale), .cos_data(cos_data), .sin_data(sin_data),
        .Re_i1(Re_i1), .Im_i1(Im_i1), .Re_i2(Re_i2), .Im_i2(Im_i2),
        .out_valid(out_valid), .Re_o1(Re_o1), .Im_o1(Im_o1), .Re_o2(Re_o2),
        .Im_o2(Im_o2), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  exp_q [$];
    int            acc_q [$];       // enabled-edge index at which each sample was captured
    int            edge_cnt = 0;    // count of enabled edges
    int            cyc = 0;         // count of all edges
    int            last_out_cyc = 0;
    logic          fire = 1'b0;     // last edge had ce=1
    logic          clr_e = 1'b0;    // last edge had ovf_clr=1
    logic          exp_ovf = 1'b0;
    logic [W-1:0]  m_e;
    int            m_a;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint rnd_q(input longint p);
        return (p + HALF) >>> (TW - 2);
    endfunction

    function automatic logic [W-1:0] model(input bit dif, input bit scl,
                                           input longint ar, input longint ai,
                                           input longint br, input longint bi,
                                           input longint c, input longint s);
        longint       yv [4];
        longint       tr, ti;
        logic [63:0]  u;
        logic [W-1:0] r;
        r = '0;
        if (dif) begin
            yv[0] = ar + br;
            yv[1] = ai + bi;
            yv[2] = rnd_q((ar - br) * c - (ai - bi) * s);
            yv[3] = rnd_q((ai - bi) * c + (ar - br) * s);
        end else begin
            tr = rnd_q(br * c - bi * s);
            ti = rnd_q(bi * c + br * s);
            yv[0] = ar + tr;
            yv[1] = ai + ti;
            yv[2] = ar - tr;
            yv[3] = ai - ti;
        end
        for (int k = 0; k < 4; k++) begin
            if (scl) yv[k] = (yv[k] + 1) >>> 1;
            if (yv[k] > MAXL || yv[k] < MINL) r[W-1] = 1'b1;
            if (yv[k] > MAXL) yv[k] = MAXL;
            else if (yv[k] < MINL) yv[k] = MINL;
            u = yv[k];
            r[(3-k)*BW +: BW] = u[BW-1:0];
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        fire  <= ce && !rst;
        clr_e <= ovf_clr && !rst;
        if (ce && !rst) edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_ovf = 1'b0;
        end else begin
            if (clr_e) exp_ovf = 1'b0;
            if (fire && out_valid) begin
                last_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    m_a = acc_q.pop_front();
                    check("sb_o1_re", $signed(Re_o1), $signed(m_e[4*BW-1 -: BW]));
                    check("sb_o1_im", $signed(Im_o1), $signed(m_e[3*BW-1 -: BW]));
                    check("sb_o2_re", $signed(Re_o2), $signed(m_e[2*BW-1 -: BW]));
                    check("sb_o2_im", $signed(Im_o2), $signed(m_e[BW-1 -: BW]));
                    // Captured at edge m_a, registered twice more: visible three
                    // cycles after the presentation cycle.
                    check("sb_latency", edge_cnt - m_a, 2);
                    if (m_e[W-1]) exp_ovf = 1'b1;
                end
            end
            check("sb_ovf", ovf, exp_ovf);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit dif, input bit scl, input int ar, input int ai,
                        input int br, input int bi, input int c, input int s);
        dif_mode = dif;
        scale    = scl;
        Re_i1    = ar[BW-1:0];
        Im_i1    = ai[BW-1:0];
        Re_i2    = br[BW-1:0];
        Im_i2    = bi[BW-1:0];
        cos_data = c[TW-1:0];
        sin_data = s[TW-1:0];
        ce       = 1'b1;
        in_valid = 1'b1;
        exp_q.push_back(model(dif, scl, ar, ai, br, bi, c, s));
        acc_q.push_back(edge_cnt + 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(fire && out_valid) && n < 20);
        if (!(fire && out_valid)) check({name, "_timeout"}, 0, 1);
    endtask

    function automatic int rand_val();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 16000)) - 8000;
    endfunction

    // ---------------- stimulus ----------------
    int n;
    int first_cyc;

    initial begin
        rst = 1'b1; ce = 1'b0; in_valid = 1'b0; dif_mode = 1'b0; scale = 1'b0;
        ovf_clr = 1'b0; cos_data = '0; sin_data = '0;
        Re_i1 = '0; Im_i1 = '0; Re_i2 = '0; Im_i2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_re_o1", Re_o1, 0);
        check("rst_im_o2", Im_o2, 0);
        rst = 1'b0;
        ce  = 1'b1;
        step();

        // DIF with W = 1
        send(1, 0, 1000, 200, 300, -100, 16384, 0);
        wait_out("dif_w1", n);
        check("dif_w1_lat", n, 2);
        check("dif_w1_o1re", $signed(Re_o1), 1300);
        check("dif_w1_o1im", $signed(Im_o1), 100);
        check("dif_w1_o2re", $signed(Re_o2), 700);
        check("dif_w1_o2im", $signed(Im_o2), 300);
        check("dif_w1_ovf", ovf, 0);

        // W = j, DIF then DIT
        send(1, 0, 100, 0, 0, 0, 0, 16384);
        wait_out("dif_wj", n);
        check("dif_wj_o1re", $signed(Re_o1), 100);
        check("dif_wj_o2re", $signed(Re_o2), 0);
        check("dif_wj_o2im", $signed(Im_o2), 100);
        send(0, 0, 1000, 0, 100, 0, 0, 16384);
        wait_out("dit_wj", n);
        check("dit_wj_o1re", $signed(Re_o1), 1000);
        check("dit_wj_o1im", $signed(Im_o1), 100);
        check("dit_wj_o2re", $signed(Re_o2), 1000);
        check("dit_wj_o2im", $signed(Im_o2), -100);

        // Rounding
        send(1, 0, 3, 0, 0, 0, 11585, 0);
        wait_out("rnd_a", n);
        check("rnd_a_o2re", $signed(Re_o2), 2);
        send(1, 0, 3, 0, 0, 0, 8192, 0);
        wait_out("rnd_half", n);
        check("rnd_half_o2re", $signed(Re_o2), 2);

        // Saturation and sticky ovf
        send(1, 0, 32767, 0, 1, 0, 16384, 0);
        wait_out("sat", n);
        check("sat_o1re", $signed(Re_o1), 32767);
        check("sat_o2re", $signed(Re_o2), 32766);
        check("sat_ovf", ovf, 1);
        step();
        check("sat_ovf_held", ovf, 1);
        send(1, 1, 32767, 0, 1, 0, 16384, 0);
        wait_out("sat_scaled", n);
        check("sat_scaled_o1re", $signed(Re_o1), 16384);
        check("sat_scaled_o2re", $signed(Re_o2), 16383);
        check("sat_scaled_ovf", ovf, 1);

        // Clear honoured during a stall
        ce = 1'b0; ovf_clr = 1'b1;
        step();
        check("clr_stalled_ovf", ovf, 0);
        ovf_clr = 1'b0; ce = 1'b1;

        // Clear and set on the same edge: set wins
        send(1, 0, 32767, 0, 1, 0, 16384, 0);
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_set_valid", out_valid, 1);
        check("clr_set_ovf", ovf, 1);

        // Reset with two samples in flight
        send(0, 0, 1234, -77, 50, 60, 9000, -3000);
        send(1, 0, -500, 400, 20, -30, 16384, 16384);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_re_o1", Re_o1, 0);
        check("midrst_re_o2", Re_o2, 0);
        exp_q.delete();
        acc_q.delete();
        step();
        rst = 1'b0;
        send(0, 1, 500, -600, 200, 300, 8192, -8192);
        wait_out("post_rst", n);
        check("post_rst_lat", n, 2);
        check("post_rst_o1re", $signed(Re_o1), 375);
        check("post_rst_o1im", $signed(Im_o1), -275);
        check("post_rst_o2re", $signed(Re_o2), 125);
        check("post_rst_o2im", $signed(Im_o2), -325);

        // Four samples, alternating modes, two stall cycles after the second
        first_cyc = cyc + 1;
        send(1, 0, rand_val(), rand_val(), rand_val(), rand_val(), rand_val(), rand_val());
        send(0, 0, rand_val(), rand_val(), rand_val(), rand_val(), rand_val(), rand_val());
        ce = 1'b0;
        step();
        step();
        send(1, 1, rand_val(), rand_val(), rand_val(), rand_val(), rand_val(), rand_val());
        send(0, 1, rand_val(), rand_val(), rand_val(), rand_val(), rand_val(), rand_val());
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        // Presentation cycle of the first sample is cycle 1.
        check("stream_last_cycle", last_out_cyc - first_cyc + 2, 9);

        // Randomized stream
        for (int i = 0; i < 400; i++) begin
            ovf_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                ce = $urandom_range(0, 1) == 1;
                step();
                ce = 1'b1;
            end else begin
                send($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     rand_val(), rand_val(), rand_val(), rand_val(),
                     rand_val(), rand_val());
            end
        end
        ovf_clr = 1'b0;
        ce = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
